sram_axi_bridge: RTL and testbench

- Arbitrates the core's instruction and data SRAM-style request ports onto one AXI4 master port.
- Sits between mycpu_top's inst/data memory interfaces and the SoC AXI interconnect.
- Drives the pipeline stall request (stallreq_axi into pip_ctrl) while a memory access is outstanding.
- Supports single-beat transfers only: one outstanding read, one outstanding write, data side has priority.

---
 rtl/cpu_defs_pkg.sv | 33 +++
 rtl/axi_wr_channel.sv | 91 +++++++++
 rtl/sram_axi_bridge.sv | 172 +++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared bus constants, FSM encodings and payload types for the SRAM-to-AXI bridge.
package cpu_defs;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned ST_W   = 2;

    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    localparam logic [ID_W-1:0] INST_ID_DEF = 4'd0;
    localparam logic [ID_W-1:0] DATA_ID_DEF = 4'd1;

    localparam logic [ST_W-1:0] R_IDLE = 2'd0;
    localparam logic [ST_W-1:0] R_AR   = 2'd1;
    localparam logic [ST_W-1:0] R_R    = 2'd2;
    localparam logic [ST_W-1:0] R_DONE = 2'd3;

    localparam logic [ST_W-1:0] W_IDLE = 2'd0;
    localparam logic [ST_W-1:0] W_AW   = 2'd1;
    localparam logic [ST_W-1:0] W_B    = 2'd2;
    localparam logic [ST_W-1:0] W_DONE = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_req_t;

endpackage

// File: rtl/axi_wr_channel.sv
// Single-beat AXI write engine: issues AW and W in parallel, waits for B, pulses done.
module axi_wr_channel
    import cpu_defs::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  wr_req_t           req,
    output logic              idle,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nx;
    logic            aw_done;
    logic            w_done;
    logic            aw_done_nx;
    logic            w_done_nx;
    logic            aw_hs;
    logic            w_hs;

    assign awvalid = (state == W_AW) & ~aw_done;
    assign wvalid  = (state == W_AW) & ~w_done;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign bready  = (state == W_B);
    assign done    = (state == W_DONE);
    assign idle    = (state == W_IDLE);
    assign busy    = (state == W_AW) | (state == W_B);

    // AW and W complete independently; B is awaited only once both have gone.
    always_comb begin
        state_nx   = state;
        aw_done_nx = aw_done;
        w_done_nx  = w_done;
        case (state)
            W_IDLE: begin
                if (start) begin
                    state_nx   = W_AW;
                    aw_done_nx = 1'b0;
                    w_done_nx  = 1'b0;
                end
            end
            W_AW: begin
                aw_done_nx = aw_done | aw_hs;
                w_done_nx  = w_done | w_hs;
                if (aw_done_nx & w_done_nx) begin
                    state_nx = W_B;
                end
            end
            W_B: begin
                if (bvalid) begin
                    state_nx = W_DONE;
                end
            end
            W_DONE:  state_nx = W_IDLE;
            default: state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= W_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else begin
            state   <= state_nx;
            aw_done <= aw_done_nx;
            w_done  <= w_done_nx;
            if ((state == W_IDLE) && start) begin
                awaddr <= req.addr;
                wdata  <= req.data;
                wstrb  <= req.strb;
            end
        end
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// Arbitrates the core's inst/data SRAM-style ports onto one single-beat AXI4 master.
module sram_axi_bridge
    import cpu_defs::*;
#(
    parameter logic [ID_W-1:0] INST_ID = INST_ID_DEF,
    parameter logic [ID_W-1:0] DATA_ID = DATA_ID_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              stallreq_axi,

    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,

    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,

    output logic [ID_W-1:0]   awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,

    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,

    input  logic [ID_W-1:0]   bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] r_state_nx;
    logic            r_is_data;
    logic            r_idle;
    logic            data_load_busy;
    logic            load_ok;
    logic            store_ok;
    logic            wr_idle;
    logic            wr_busy;
    logic            wr_done;
    wr_req_t         wr_req;

    // Responses carry no error handling and routing uses the latched id.
    logic unused_resp;
    assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

    assign arlen   = LEN_SINGLE;
    assign arsize  = SIZE_WORD;
    assign arburst = BURST_INCR;
    assign awlen   = LEN_SINGLE;
    assign awsize  = SIZE_WORD;
    assign awburst = BURST_INCR;
    assign awid    = DATA_ID;
    assign wlast   = wvalid;

    // Data side wins reads; loads wait for any store so they never overtake it.
    assign r_idle         = (r_state == R_IDLE);
    assign data_load_busy = ~r_idle & r_is_data;
    assign load_ok        = data_req & ~data_wr & r_idle & wr_idle;
    assign store_ok       = data_req & data_wr & wr_idle & ~data_load_busy;
    assign data_addr_ok   = load_ok | store_ok;
    assign inst_addr_ok   = inst_req & r_idle & ~load_ok;

    assign arvalid      = (r_state == R_AR);
    assign rready       = (r_state == R_R);
    assign inst_data_ok = (r_state == R_DONE) & ~r_is_data;
    assign data_data_ok = ((r_state == R_DONE) & r_is_data) | wr_done;

    assign stallreq_axi = (inst_req & ~inst_addr_ok)
                        | (data_req & ~data_addr_ok)
                        | (r_state == R_AR) | (r_state == R_R)
                        | wr_busy;

    always_comb begin
        r_state_nx = r_state;
        case (r_state)
            R_IDLE:  if (load_ok | inst_addr_ok) r_state_nx = R_AR;
            R_AR:    if (arready) r_state_nx = R_R;
            R_R:     if (rvalid) r_state_nx = R_DONE;
            R_DONE:  r_state_nx = R_IDLE;
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= R_IDLE;
            r_is_data  <= 1'b0;
            araddr     <= '0;
            arid       <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            r_state <= r_state_nx;
            if (load_ok) begin
                araddr    <= data_addr;
                arid      <= DATA_ID;
                r_is_data <= 1'b1;
            end else if (inst_addr_ok) begin
                araddr    <= inst_addr;
                arid      <= INST_ID;
                r_is_data <= 1'b0;
            end
            if ((r_state == R_R) && rvalid) begin
                if (r_is_data) begin
                    data_rdata <= rdata;
                end else begin
                    inst_rdata <= rdata;
                end
            end
        end
    end

    always_comb begin
        wr_req      = '0;
        wr_req.addr = data_addr;
        wr_req.data = data_wdata;
        wr_req.strb = data_wstrb;
    end

    axi_wr_channel u_wr (
        .clk     (clk),
        .reset   (reset),
        .start   (store_ok),
        .req     (wr_req),
        .idle    (wr_idle),
        .busy    (wr_busy),
        .done    (wr_done),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bvalid  (bvalid),
        .bready  (bready)
    );

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with hand-computed expected values per cycle.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        stallreq_axi;
    logic [3:0]  arid, awid;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, awvalid, wvalid, wlast, rready, bready;
    logic        arready = 1'b0, awready = 1'b0, wready = 1'b0;
    logic [3:0]  rid = '0, bid = '0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0, bresp = '0;
    logic        rlast = 1'b0, rvalid = 1'b0, bvalid = 1'b0;
    logic [3:0]  wstrb;

    int checks = 0;
    int errors = 0;
    int n_inst_ok = 0;
    int n_data_ok = 0;
    int base_i, base_d;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .stallreq_axi(stallreq_axi),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // Pulse counters for data_ok, sampled away from the active edge.
    always @(negedge clk) begin
        if (inst_data_ok) n_inst_ok++;
        if (data_data_ok) n_data_ok++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        @(negedge clk);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready",  32'(rready),  32'd0);
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid",  32'(wvalid),  32'd0);
        check("rst_bready",  32'(bready),  32'd0);
        check("rst_stall",   32'(stallreq_axi), 32'd0);
        check("rst_araddr",  araddr, 32'd0);
        check("rst_awaddr",  awaddr, 32'd0);
        check("rst_arlen",   32'(arlen),   32'd0);
        check("rst_arsize",  32'(arsize),  32'd2);
        check("rst_awburst", 32'(awburst), 32'd1);
        tick(); reset = 1'b0;
        tick();

        // Fetch with arready=1, rvalid three cycles after AR
        base_i = n_inst_ok;
        inst_req = 1'b1; inst_addr = 32'h1C00_0000;
        @(negedge clk);
        check("f_addr_ok", 32'(inst_addr_ok), 32'd1);
        check("f_arvalid_T", 32'(arvalid), 32'd0);
        tick(); inst_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        check("f_arvalid_T1", 32'(arvalid), 32'd1);
        check("f_araddr", araddr, 32'h1C00_0000);
        check("f_arid", 32'(arid), 32'd0);
        check("f_stall_ar", 32'(stallreq_axi), 32'd1);
        tick(); arready = 1'b0;
        @(negedge clk);
        check("f_rready", 32'(rready), 32'd1);
        check("f_arvalid_drop", 32'(arvalid), 32'd0);
        tick();
        tick(); rvalid = 1'b1; rdata = 32'h0280_0C0C;
        @(negedge clk);
        check("f_no_early_ok", 32'(inst_data_ok), 32'd0);
        tick(); rvalid = 1'b0; rdata = '0;
        @(negedge clk);
        check("f_data_ok", 32'(inst_data_ok), 32'd1);
        check("f_rdata", inst_rdata, 32'h0280_0C0C);
        tick();
        check("f_ok_once", 32'(n_inst_ok - base_i), 32'd1);
        @(negedge clk);
        check("f_stall_after", 32'(stallreq_axi), 32'd0);
        check("f_ok_drop", 32'(inst_data_ok), 32'd0);

        // Simultaneous fetch and data load: data wins
        tick();
        inst_req = 1'b1; inst_addr = 32'h1C00_0004;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_1000;
        @(negedge clk);
        check("arb_data_ok", 32'(data_addr_ok), 32'd1);
        check("arb_inst_ok", 32'(inst_addr_ok), 32'd0);
        check("arb_stall", 32'(stallreq_axi), 32'd1);
        tick(); data_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        check("arb_araddr", araddr, 32'h0000_1000);
        check("arb_arid", 32'(arid), 32'd1);
        check("arb_inst_wait1", 32'(inst_addr_ok), 32'd0);
        tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h1122_3344;
        @(negedge clk);
        check("arb_inst_wait2", 32'(inst_addr_ok), 32'd0);
        tick(); rvalid = 1'b0;
        @(negedge clk);
        check("arb_ddata_ok", 32'(data_data_ok), 32'd1);
        check("arb_drdata", data_rdata, 32'h1122_3344);
        check("arb_inst_wait3", 32'(inst_addr_ok), 32'd0);
        tick();
        @(negedge clk);
        check("arb_inst_go", 32'(inst_addr_ok), 32'd1);
        tick(); inst_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        check("arb_f_araddr", araddr, 32'h1C00_0004);
        check("arb_f_arid", 32'(arid), 32'd0);
        tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_5555;
        tick(); rvalid = 1'b0;
        @(negedge clk);
        check("arb_f_ok", 32'(inst_data_ok), 32'd1);
        check("arb_f_rdata", inst_rdata, 32'h0000_5555);
        tick();

        // Store with awready two cycles before wready
        base_d = n_data_ok;
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
        data_addr = 32'h0000_2000; data_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("st_addr_ok", 32'(data_addr_ok), 32'd1);
        tick(); data_req = 1'b0; data_wr = 1'b0; awready = 1'b1;
        @(negedge clk);
        check("st_awvalid", 32'(awvalid), 32'd1);
        check("st_wvalid", 32'(wvalid), 32'd1);
        check("st_awaddr", awaddr, 32'h0000_2000);
        check("st_wdata", wdata, 32'hDEAD_BEEF);
        check("st_wstrb", 32'(wstrb), 32'b0011);
        check("st_wlast", 32'(wlast), 32'd1);
        check("st_awid", 32'(awid), 32'd1);
        tick(); awready = 1'b0;
        @(negedge clk);
        check("st_aw_drop", 32'(awvalid), 32'd0);
        check("st_w_hold1", 32'(wvalid), 32'd1);
        tick(); wready = 1'b1;
        @(negedge clk);
        check("st_w_hold2", 32'(wvalid), 32'd1);
        tick(); wready = 1'b0;
        @(negedge clk);
        check("st_w_drop", 32'(wvalid), 32'd0);
        check("st_bready", 32'(bready), 32'd1);
        tick(); bvalid = 1'b1;
        @(negedge clk);
        check("st_no_early_ok", 32'(data_data_ok), 32'd0);
        tick(); bvalid = 1'b0;
        @(negedge clk);
        check("st_data_ok", 32'(data_data_ok), 32'd1);
        check("st_stall_done", 32'(stallreq_axi), 32'd0);
        tick();
        check("st_ok_once", 32'(n_data_ok - base_d), 32'd1);

        // Store then load to the same address with B delayed five cycles
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
        data_addr = 32'h0000_2000; data_wdata = 32'h1234_5678;
        @(negedge clk);
        check("sl_st_ok", 32'(data_addr_ok), 32'd1);
        tick(); data_wr = 1'b0; awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        check("sl_ld_blocked", 32'(data_addr_ok), 32'd0);
        check("sl_ld_stall", 32'(stallreq_axi), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick(); awready = 1'b0; wready = 1'b0;
            @(negedge clk);
            check("sl_wait_ok", 32'(data_addr_ok), 32'd0);
            check("sl_wait_stall", 32'(stallreq_axi), 32'd1);
        end
        tick(); bvalid = 1'b1;
        @(negedge clk);
        check("sl_b_ok", 32'(data_addr_ok), 32'd0);
        tick(); bvalid = 1'b0;
        @(negedge clk);
        check("sl_st_done", 32'(data_data_ok), 32'd1);
        check("sl_ld_still", 32'(data_addr_ok), 32'd0);
        tick();
        @(negedge clk);
        check("sl_ld_accept", 32'(data_addr_ok), 32'd1);
        tick(); data_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        check("sl_arvalid", 32'(arvalid), 32'd1);
        check("sl_araddr", araddr, 32'h0000_2000);
        check("sl_arid", 32'(arid), 32'd1);
        tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        tick(); rvalid = 1'b0;
        @(negedge clk);
        check("sl_ld_ok", 32'(data_data_ok), 32'd1);
        check("sl_ld_rdata", data_rdata, 32'hCAFE_F00D);
        tick();

        // arready held low for ten cycles
        base_i = n_inst_ok; base_d = n_data_ok;
        inst_req = 1'b1; inst_addr = 32'h1C00_0100;
        @(negedge clk);
        check("bp_addr_ok", 32'(inst_addr_ok), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick(); inst_req = 1'b0;
            @(negedge clk);
            check("bp_arvalid", 32'(arvalid), 32'd1);
            check("bp_araddr", araddr, 32'h1C00_0100);
        end
        tick();
        check("bp_no_ok", 32'((n_inst_ok - base_i) + (n_data_ok - base_d)), 32'd0);
        arready = 1'b1;
        tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0100;
        tick(); rvalid = 1'b0;
        @(negedge clk);
        check("bp_done", 32'(inst_data_ok), 32'd1);
        tick();

        // Reset while in R_R
        base_i = n_inst_ok; base_d = n_data_ok;
        inst_req = 1'b1; inst_addr = 32'h1C00_0200;
        tick(); inst_req = 1'b0; arready = 1'b1;
        tick(); arready = 1'b0;
        @(negedge clk);
        check("rr_in_r", 32'(rready), 32'd1);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        @(negedge clk);
        check("rr_arvalid", 32'(arvalid), 32'd0);
        check("rr_rready", 32'(rready), 32'd0);
        check("rr_stall", 32'(stallreq_axi), 32'd0);
        tick(); tick();
        check("rr_no_ok", 32'((n_inst_ok - base_i) + (n_data_ok - base_d)), 32'd0);
        inst_req = 1'b1; inst_addr = 32'h1C00_0300;
        @(negedge clk);
        check("rr_new_ok", 32'(inst_addr_ok), 32'd1);
        tick(); inst_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        check("rr_new_araddr", araddr, 32'h1C00_0300);
        tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_AAAA;
        tick(); rvalid = 1'b0;
        @(negedge clk);
        check("rr_new_data_ok", 32'(inst_data_ok), 32'd1);
        check("rr_new_rdata", inst_rdata, 32'h0000_AAAA);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
